weapon_bank_controller: RTL
===========================

// Module: weapon_bank_controller
// PURPOSE
//  Multi-channel successor to the single ammo counter. It manages N_CH independent weapon
//  channels. Each channel has a saturating ammo count, a per-channel fire rate, a timed
//  reload and a post-shot cooldown. Fire is gated by the ship mode selector (attack mode
//  only), and illegal requests are reported as registered error codes. It sits between
//  the command decoder (mode/trigger/reload requests) and the ammo display/status logic.
// PARAMETERS
//  N_CH          4       number of weapon channels
//  AMMO_W        9       ammo count width (max capacity 2^AMMO_W-1 = 511)
//  RATE_W        4       per-channel fire-rate width (rounds consumed per shot)
//  RELOAD_CYC    8       cycles from reload request to ammo update (>=1)
//  COOLDOWN_CYC  2       lockout cycles after a shot (0 = fire every cycle)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  mode_sel   in   4              ship mode; 4'b0010 = attack
//  fire       in   N_CH           per-channel trigger, level, sampled each edge
//  fire_rate  in   N_CH*RATE_W    rounds per shot, channel i at [i*RATE_W +: RATE_W]
//  load_req   in   1              start reload of channel ch_sel
//  ch_sel     in   $clog2(N_CH)   channel addressed by load_req
//  load_ammo  in   AMMO_W         rounds supplied by reload, latched at load_req
//  cap_load   in   1              write bank capacity register from cap_in
//  cap_in     in   AMMO_W         new capacity
//  ammo_out   out  N_CH*AMMO_W    current ammo per channel
//  busy       out  N_CH           channel reloading
//  shot       out  N_CH           1-cycle pulse: a round group was fired
//  error      out  1              1-cycle pulse: some request was illegal this cycle
//  err_code   out  2              0 none, 1 MODE, 2 EMPTY, 3 BUSY
// BEHAVIOUR
//  Reset (async): all ammo=0, busy=0, shot=0, error=0, err_code=0, every FSM in READY,
//   capacity=2^AMMO_W-1. A reset during a reload aborts the reload and discards the
//   latched rounds.
//  Per-channel FSM: READY, RELOAD, COOLDOWN. All outputs are registered.
//  READY and fire[i]:
//   - mode_sel != attack: no change, ERR_MODE.
//   - ammo==0: ERR_EMPTY.
//   - otherwise: ammo <= ammo - min(rate, ammo), saturating at 0; shot[i]=1 next cycle;
//     go to COOLDOWN if COOLDOWN_CYC>0, else stay in READY.
//   - fire_rate==0 is treated as 1.
//  COOLDOWN: count COOLDOWN_CYC edges, then READY. Fire during COOLDOWN is silently
//   ignored (no error). load_req in COOLDOWN is accepted.
//  load_req (channel ch_sel, in READY or COOLDOWN): latch
//   target = min(ammo + load_ammo, capacity), computed at AMMO_W+1 bits. busy=1 from the
//   next cycle. Exactly RELOAD_CYC edges after the request edge, ammo<=target, busy=0,
//   state=READY.
//  RELOAD: fire -> ERR_BUSY. A load_req to a busy channel is ignored -> ERR_BUSY.
//  Same-edge fire[i] and load_req to i in READY: the load wins, the fire is dropped, ERR_BUSY.
//  cap_load: the capacity updates next edge. Counts above the new capacity are NOT
//   truncated; only future reloads clamp.
//  The up-count never wraps and the down-count never underflows.
//  Error reporting: error/err_code are registered, 1 cycle after the offending edge.
//   If several channels fault at once, the lowest channel index supplies err_code.
//   A load_req fault outranks channel faults. Legal activity elsewhere proceeds
//   unaffected.
// STRUCTURE
//  Shared package weapons_pkg: ATTACK_MODE=4'b0010; err codes ERR_NONE/MODE/EMPTY/BUSY;
//   channel state encoding READY/RELOAD/COOLDOWN.
//  Sub-module weapon_channel: FSM, ammo register, reload/cooldown timer, per-channel
//   fault flag.
//  Top level: generate N_CH instances, ch_sel decode, the capacity register and the
//   error priority encoder.
// TESTING
//  1. Reset, attack mode, reload ch0 with 500, wait 8 cycles -> ammo0=500, busy0 high
//     exactly 8 cycles.
//  2. ch0=500, rate=5, fire held, COOLDOWN_CYC=2 -> shot every 3rd cycle, 495, 490, ...,
//     0, then ERR_EMPTY per attempt.
//  3. ammo=3, rate=5, fire -> ammo=0 (no wrap), shot=1; rate=0 -> consumes 1 per shot.
//  4. mode_sel=4'b0001, fire ch1 -> ammo unchanged, error=1, err_code=1 next cycle.
//  5. Fire ch2 during reload plus a load_req to ch2 -> ERR_BUSY, ammo unchanged; same-edge
//     fire+load on ch3 -> reload starts, no shot.
//  6. cap=200, ammo=150, reload 100 -> 200; assert rst mid-reload -> ammo=0, busy=0
//     immediately.

Source files
------------

// File: rtl/weapons_pkg.sv
// Shared types for the weapon bank: ship mode constant, error codes and channel states.
package weapons_pkg;

    localparam logic [3:0] ATTACK_MODE = 4'b0010;

    typedef enum logic [1:0] {
        ErrNone  = 2'd0,
        ErrMode  = 2'd1,
        ErrEmpty = 2'd2,
        ErrBusy  = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        StReady    = 2'd0,
        StReload   = 2'd1,
        StCooldown = 2'd2
    } ch_state_e;

endpackage

// File: rtl/weapon_bank_controller_if.sv
// Command/status bundle between the command decoder, the weapon bank and the ammo display.
interface weapon_bank_controller_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned AMMO_W = 9,
    parameter int unsigned RATE_W = 4
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [3:0]             mode_sel;
    logic [N_CH-1:0]        fire;
    logic [N_CH*RATE_W-1:0] fire_rate;
    logic                   load_req;
    logic [SEL_W-1:0]       ch_sel;
    logic [AMMO_W-1:0]      load_ammo;
    logic                   cap_load;
    logic [AMMO_W-1:0]      cap_in;
    logic [N_CH*AMMO_W-1:0] ammo_out;
    logic [N_CH-1:0]        busy;
    logic [N_CH-1:0]        shot;
    logic                   error;
    logic [1:0]             err_code;

    modport master (
        output mode_sel, fire, fire_rate, load_req, ch_sel, load_ammo, cap_load, cap_in,
        input  ammo_out, busy, shot, error, err_code
    );

    modport slave (
        input  mode_sel, fire, fire_rate, load_req, ch_sel, load_ammo, cap_load, cap_in,
        output ammo_out, busy, shot, error, err_code
    );

endinterface

// File: rtl/weapon_channel.sv
// One weapon channel: READY/RELOAD/COOLDOWN FSM, saturating ammo register and shared timer.
module weapon_channel
    import weapons_pkg::*;
#(
    parameter int unsigned AMMO_W       = 9,
    parameter int unsigned RATE_W       = 4,
    parameter int unsigned RELOAD_CYC   = 8,
    parameter int unsigned COOLDOWN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic              attack,
    input  logic              load,
    input  logic [RATE_W-1:0] rate,
    input  logic [AMMO_W-1:0] load_ammo,
    input  logic [AMMO_W-1:0] capacity,
    output logic [AMMO_W-1:0] ammo,
    output logic              busy,
    output logic              shot,
    output err_e              fault
);

    localparam int unsigned TMAX  = (RELOAD_CYC > COOLDOWN_CYC) ? RELOAD_CYC : COOLDOWN_CYC;
    localparam int unsigned TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] RL_INIT = TMR_W'(RELOAD_CYC - 1);
    localparam logic [TMR_W-1:0] CD_INIT = (COOLDOWN_CYC > 0) ? TMR_W'(COOLDOWN_CYC - 1) : '0;

    ch_state_e         state_q, state_d;
    logic [AMMO_W-1:0] ammo_q, ammo_d, target_q, target_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              shot_q, shot_d;

    logic [AMMO_W:0]   sum;
    logic [AMMO_W-1:0] capped;
    logic [AMMO_W-1:0] step;

    always_comb begin
        // Sum kept one bit wider so a full bank plus a large reload cannot wrap.
        sum    = {1'b0, ammo_q} + {1'b0, load_ammo};
        capped = (sum > {1'b0, capacity}) ? capacity : sum[AMMO_W-1:0];
        step   = (rate == '0) ? AMMO_W'(1) : AMMO_W'(rate);
    end

    always_comb begin
        state_d  = state_q;
        ammo_d   = ammo_q;
        target_d = target_q;
        timer_d  = timer_q;
        shot_d   = 1'b0;
        fault    = ErrNone;
        unique case (state_q)
            StReady: begin
                if (load) begin
                    state_d  = StReload;
                    target_d = capped;
                    timer_d  = RL_INIT;
                    if (fire) fault = ErrBusy;
                end else if (fire) begin
                    if (!attack) begin
                        fault = ErrMode;
                    end else if (ammo_q == '0) begin
                        fault = ErrEmpty;
                    end else begin
                        ammo_d = (ammo_q > step) ? ammo_q - step : '0;
                        shot_d = 1'b1;
                        if (COOLDOWN_CYC > 0) begin
                            state_d = StCooldown;
                            timer_d = CD_INIT;
                        end
                    end
                end
            end
            StCooldown: begin
                if (load) begin
                    state_d  = StReload;
                    target_d = capped;
                    timer_d  = RL_INIT;
                end else if (timer_q == '0) begin
                    state_d = StReady;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StReload: begin
                if (fire) fault = ErrBusy;
                if (timer_q == '0) begin
                    ammo_d  = target_q;
                    state_d = StReady;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StReady;
            ammo_q   <= '0;
            target_q <= '0;
            timer_q  <= '0;
            shot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ammo_q   <= ammo_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            shot_q   <= shot_d;
        end
    end

    assign ammo = ammo_q;
    assign busy = (state_q == StReload);
    assign shot = shot_q;

endmodule

// File: rtl/weapon_bank_controller.sv
// Bank of weapon channels with a shared capacity register and registered error reporting.
module weapon_bank_controller
    import weapons_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned AMMO_W       = 9,
    parameter int unsigned RATE_W       = 4,
    parameter int unsigned RELOAD_CYC   = 8,
    parameter int unsigned COOLDOWN_CYC = 2
) (
    input logic                     clk,
    input logic                     rst,
    weapon_bank_controller_if.slave bus
);

    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [AMMO_W-1:0]      cap_q;
    logic                   err_q;
    err_e                   code_q, code_d;
    logic                   attack;
    logic [N_CH*AMMO_W-1:0] ammo_flat;
    logic [N_CH-1:0]        busy_flat;
    logic [N_CH-1:0]        shot_flat;
    err_e                   fault [N_CH];

    assign attack = (bus.mode_sel == ATTACK_MODE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        weapon_channel #(
            .AMMO_W      (AMMO_W),
            .RATE_W      (RATE_W),
            .RELOAD_CYC  (RELOAD_CYC),
            .COOLDOWN_CYC(COOLDOWN_CYC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .fire     (bus.fire[i]),
            .attack   (attack),
            .load     (bus.load_req && (bus.ch_sel == SEL_W'(i))),
            .rate     (bus.fire_rate[i*RATE_W +: RATE_W]),
            .load_ammo(bus.load_ammo),
            .capacity (cap_q),
            .ammo     (ammo_flat[i*AMMO_W +: AMMO_W]),
            .busy     (busy_flat[i]),
            .shot     (shot_flat[i]),
            .fault    (fault[i])
        );
    end

    // Lowest faulting channel wins; a rejected reload request overrides them all.
    always_comb begin
        code_d = ErrNone;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fault[i] != ErrNone) code_d = fault[i];
        end
        if (bus.load_req && (32'(bus.ch_sel) < N_CH) && busy_flat[bus.ch_sel]) code_d = ErrBusy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '1;
            err_q  <= 1'b0;
            code_q <= ErrNone;
        end else begin
            if (bus.cap_load) cap_q <= bus.cap_in;
            err_q  <= (code_d != ErrNone);
            code_q <= code_d;
        end
    end

    assign bus.ammo_out = ammo_flat;
    assign bus.busy     = busy_flat;
    assign bus.shot     = shot_flat;
    assign bus.error    = err_q;
    assign bus.err_code = code_q;

endmodule
